rvc_fetch_decompressor: RTL and testbench

Sequential RV32C fetch-side decompression stage between instruction memory and decode. It accepts 32-bit fetch words and buffers them as halfwords. Instructions, including 32-bit ones that straddle word boundaries, are realigned, and compressed encodings are expanded to their 32-bit equivalents. Each instruction is presented to decode with its PC and a compressed flag over a valid/ready handshake.

---
 rtl/rvc_fetch_decompressor.sv | 238 +++++++++++++++++++++++
 tb/tb_rvc_fetch_decompressor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_decompressor.sv
// rvc_fetch_decompressor
// RV32C fetch-side realignment and expansion stage. Fetch words enter a
// halfword circular queue; the head halfword (plus its successor for 32-bit
// instructions) is classified, expanded if compressed, and presented to
// decode with its PC over a valid/ready handshake.
// Optional build macro: RVC_ILLEGAL_CHECK_EN adds the out_illegal port.
module rvc_fetch_decompressor #(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_pc,
   output logic        out_compressed
`ifdef RVC_ILLEGAL_CHECK_EN
   ,
   output logic        out_illegal
`endif
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_M2 = CW'(QUEUE_DEPTH - 2);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [15:0]    q_mem [QUEUE_DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  count;
   logic [31:0]    pc;
   logic           skip_low;

   logic [15:0]    head_lo;
   logic [15:0]    head_hi;
   logic           head_is_c;
   logic           head_ill;
   logic [31:0]    head_exp;
   logic           push;
   logic           pop;
   logic [CW-1:0]  push_n;
   logic [CW-1:0]  pop_n;

   // Encodings that have no RV32C integer meaning (reserved, FP, RV64-only).
   function automatic logic rvc_illegal(input logic [15:0] c);
      logic ill;
      ill = 1'b0;
      case (c[1:0])
         2'b00: begin
            case (c[15:13])
               3'b000:  ill = (c[12:5] == 8'd0);
               3'b010,
               3'b110:  ill = 1'b0;
               default: ill = 1'b1;
            endcase
         end
         2'b01: begin
            case (c[15:13])
               3'b011:  ill = ({c[12], c[6:2]} == 6'd0);
               3'b100:  ill = c[12] && (c[11:10] != 2'b10);
               default: ill = 1'b0;
            endcase
         end
         2'b10: begin
            case (c[15:13])
               3'b000:  ill = c[12];
               3'b010:  ill = (c[11:7] == 5'd0);
               3'b100:  ill = !c[12] && (c[6:2] == 5'd0) && (c[11:7] == 5'd0);
               3'b110:  ill = 1'b0;
               default: ill = 1'b1;
            endcase
         end
         default: ill = 1'b0;
      endcase
      return ill;
   endfunction

   // 32-bit equivalent of a legal compressed encoding.
   function automatic logic [31:0] rvc_expand(input logic [15:0] c);
      logic [31:0] ins;
      logic [4:0]  rd;
      logic [4:0]  rs2;
      logic [4:0]  rdp;
      logic [4:0]  rs1p;
      logic [20:0] joff;
      logic [12:0] boff;
      rd   = c[11:7];
      rs2  = c[6:2];
      rdp  = {2'b01, c[4:2]};
      rs1p = {2'b01, c[9:7]};
      joff = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
      boff = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
      ins  = 32'h0000_0000;
      case (c[1:0])
         2'b00: begin
            case (c[15:13])
               3'b000:  ins = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
               3'b010:  ins = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OP_LOAD};
               3'b110:  ins = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, OP_STORE};
               default: ins = 32'h0000_0000;
            endcase
         end
         2'b01: begin
            case (c[15:13])
               3'b000: ins = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, OP_IMM};
               3'b001: ins = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, OP_JAL};
               3'b010: ins = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, OP_IMM};
               3'b011: begin
                  if (rd == 5'd2)
                     ins = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
                  else
                     ins = {{15{c[12]}}, c[6:2], rd, OP_LUI};
               end
               3'b100: begin
                  case (c[11:10])
                     2'b00: ins = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                     2'b01: ins = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                     2'b10: ins = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, OP_IMM};
                     default: begin
                        case (c[6:5])
                           2'b00:   ins = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_OP};
                           2'b01:   ins = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_OP};
                           2'b10:   ins = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_OP};
                           default: ins = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_OP};
                        endcase
                     end
                  endcase
               end
               3'b101:  ins = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, OP_JAL};
               3'b110:  ins = {boff[12], boff[10:5], 5'd0, rs1p, 3'b000, boff[4:1], boff[11], OP_BRANCH};
               default: ins = {boff[12], boff[10:5], 5'd0, rs1p, 3'b001, boff[4:1], boff[11], OP_BRANCH};
            endcase
         end
         2'b10: begin
            case (c[15:13])
               3'b000: ins = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};
               3'b010: ins = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LOAD};
               3'b100: begin
                  if (!c[12]) begin
                     if (rs2 == 5'd0) ins = {12'd0, rd, 3'b000, 5'd0, OP_JALR};
                     else             ins = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_OP};
                  end else begin
                     if (rs2 == 5'd0 && rd == 5'd0) ins = 32'h0010_0073;
                     else if (rs2 == 5'd0)          ins = {12'd0, rd, 3'b000, 5'd1, OP_JALR};
                     else                           ins = {7'b0000000, rs2, rd, 3'b000, rd, OP_OP};
                  end
               end
               3'b110:  ins = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, OP_STORE};
               default: ins = 32'h0000_0000;
            endcase
         end
         default: ins = 32'h0000_0000;
      endcase
      return ins;
   endfunction

   // Head classification and handshake; fetch_ready looks only at the registered count.
   always_comb begin
      head_lo     = q_mem[head];
      head_hi     = q_mem[head + PW'(1)];
      head_is_c   = (head_lo[1:0] != 2'b11);
      head_ill    = rvc_illegal(head_lo);
      head_exp    = head_ill ? {16'h0000, head_lo} : rvc_expand(head_lo);
      fetch_ready = (count <= DEPTH_M2);
      out_valid   = head_is_c ? (count >= CW'(1)) : (count >= CW'(2));
      push        = fetch_valid && fetch_ready;
      pop         = out_valid && out_ready;
      push_n      = !push ? CW'(0) : (skip_low ? CW'(1) : CW'(2));
      pop_n       = !pop ? CW'(0) : (head_is_c ? CW'(1) : CW'(2));
   end

   // Presented instruction; forced to zero when nothing is valid so no X leaks out.
   always_comb begin
      out_instruction = 32'h0000_0000;
      if (out_valid)
         out_instruction = head_is_c ? head_exp : {head_hi, head_lo};
      out_compressed = out_valid && head_is_c;
      out_pc         = pc;
   end

`ifdef RVC_ILLEGAL_CHECK_EN
   // Illegal flag only accompanies a valid compressed head.
   always_comb begin
      out_illegal = out_valid && head_is_c && head_ill;
   end
`endif

   // Queue storage, pointers, PC and redirect handling; flush outranks push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) q_mem[i] <= 16'h0000;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         pc       <= RESET_PC;
         skip_low <= 1'b0;
      end else if (flush) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         pc       <= flush_pc & 32'hFFFF_FFFE;
         skip_low <= flush_pc[1];
      end else begin
         if (push) begin
            if (skip_low) begin
               q_mem[tail] <= fetch_data[31:16];
               tail        <= tail + PW'(1);
               skip_low    <= 1'b0;
            end else begin
               q_mem[tail]          <= fetch_data[15:0];
               q_mem[tail + PW'(1)] <= fetch_data[31:16];
               tail                 <= tail + PW'(2);
            end
         end
         if (pop) begin
            head <= head + (head_is_c ? PW'(1) : PW'(2));
            pc   <= pc + (head_is_c ? 32'd2 : 32'd4);
         end
         count <= count + push_n - pop_n;
      end
   end

endmodule

// File: tb/tb_rvc_fetch_decompressor.sv
// Directed bench for rvc_fetch_decompressor with an expected-instruction
// scoreboard filled as words are driven and drained by an output monitor.
module tb_rvc_fetch_decompressor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic [31:0] flush_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic        out_compressed;
`ifdef RVC_ILLEGAL_CHECK_EN
   logic        out_illegal;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        comp;
      logic        ill;
   } exp_t;

   exp_t sb[$];

   rvc_fetch_decompressor #(.QUEUE_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .flush           (flush),
      .flush_pc        (flush_pc),
      .fetch_valid     (fetch_valid),
      .fetch_ready     (fetch_ready),
      .fetch_data      (fetch_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .out_compressed  (out_compressed)
`ifdef RVC_ILLEGAL_CHECK_EN
      ,
      .out_illegal     (out_illegal)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic expect_ins(input logic [31:0] ins, input logic [31:0] pc,
                             input logic comp, input logic ill);
      exp_t e;
      e.ins = ins; e.pc = pc; e.comp = comp; e.ill = ill;
      sb.push_back(e);
   endtask

   // Drive one word and hold it until the queue takes it.
   task automatic send_word(input logic [31:0] w);
      int t;
      t = 0;
      fetch_data  = w;
      fetch_valid = 1'b1;
      @(negedge clk);
      while (!fetch_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!fetch_ready) check("send_timeout", 32'(fetch_ready), 32'd1);
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
   endtask

   task automatic do_flush(input logic [31:0] p);
      flush    = 1'b1;
      flush_pc = p;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int t;
      t = 0;
      while (sb.size() != 0 && t < max_cycles) begin
         @(posedge clk);
         t++;
      end
      n_cmp++;
      assert (sb.size() == 0) else begin
         n_bad++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
      end
      #1;
      check("drained_idle", 32'(out_valid), 32'd0);
   endtask

   // Output monitor: every accepted instruction is compared with the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && out_valid && out_ready) begin
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_out: observed %h at %h expected none", out_instruction, out_pc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_instruction", out_instruction, e.ins);
            check("out_pc", out_pc, e.pc);
            check("out_compressed", 32'(out_compressed), 32'(e.comp));
`ifdef RVC_ILLEGAL_CHECK_EN
            check("out_illegal", 32'(out_illegal), 32'(e.ill));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      flush       = 1'b0;
      flush_pc    = 32'h0;
      fetch_valid = 1'b0;
      fetch_data  = 32'h0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
      check("rst_out_compressed", 32'(out_compressed), 32'd0);
      check("rst_out_pc", out_pc, 32'h0000_0000);
`ifdef RVC_ILLEGAL_CHECK_EN
      check("rst_out_illegal", 32'(out_illegal), 32'd0);
`endif
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // c.addi x8,1 then c.add x10,x11 from one word
      out_ready = 1'b1;
      expect_ins(32'h0014_0413, 32'h0, 1'b1, 1'b0);
      expect_ins(32'h00B5_0533, 32'h2, 1'b1, 1'b0);
      send_word(32'h952E_0405);
      check("latency_valid", 32'(out_valid), 32'd1);
      wait_drain(20);

      // straddling 32-bit instruction
      do_flush(32'h0);
      expect_ins(32'h0014_0413, 32'h0, 1'b1, 1'b0);
      expect_ins(32'h0000_0013, 32'h2, 1'b0, 1'b0);
      expect_ins(32'h0014_0413, 32'h6, 1'b1, 1'b0);
      send_word(32'h0013_0405);
      @(posedge clk);
      #1;
      check("straddle_wait", 32'(out_valid), 32'd0);
      send_word(32'h0405_0000);
      wait_drain(20);

      // aligned redirect; upper halfword 0000 is the all-zero encoding
      do_flush(32'h100);
      expect_ins(32'h4094_0433, 32'h100, 1'b1, 1'b0);
      expect_ins(32'h0000_0000, 32'h102, 1'b1, 1'b1);
      send_word(32'h0000_8C05);
      wait_drain(20);

      // misaligned redirect drops the low halfword
      do_flush(32'h102);
      expect_ins(32'h4094_0433, 32'h102, 1'b1, 1'b0);
      send_word(32'h8C05_1234);
      wait_drain(20);

      // expansion vectors across all quadrants
      do_flush(32'h200);
      expect_ins(32'h0045_2483, 32'h200, 1'b1, 1'b0);
      expect_ins(32'hFFFF_F06F, 32'h202, 1'b1, 1'b0);
      expect_ins(32'h0004_1463, 32'h204, 1'b1, 1'b0);
      expect_ins(32'h00C1_2083, 32'h206, 1'b1, 1'b0);
      expect_ins(32'h0011_2423, 32'h208, 1'b1, 1'b0);
      expect_ins(32'h0000_8067, 32'h20A, 1'b1, 1'b0);
      expect_ins(32'h0000_1537, 32'h20C, 1'b1, 1'b0);
      expect_ins(32'h0101_0413, 32'h20E, 1'b1, 1'b0);
      expect_ins(32'h4044_5413, 32'h210, 1'b1, 1'b0);
      expect_ins(32'h0095_2223, 32'h212, 1'b1, 1'b0);
      expect_ins(32'h0000_6000, 32'h214, 1'b1, 1'b1);
      expect_ins(32'h0000_0013, 32'h216, 1'b1, 1'b0);
      expect_ins(32'h00B5_0533, 32'h218, 1'b0, 1'b0);
      send_word(32'hBFFD_4144);
      send_word(32'h40B2_E401);
      send_word(32'h8082_C406);
      send_word(32'h0800_6505);
      send_word(32'hC144_8411);
      send_word(32'h0001_6000);
      send_word(32'h00B5_0533);
      wait_drain(40);

      // fill with decode stalled, outputs hold, then drain in order
      do_flush(32'h0);
      out_ready = 1'b0;
      expect_ins(32'h0014_0413, 32'h0, 1'b1, 1'b0);
      expect_ins(32'h0024_0413, 32'h2, 1'b1, 1'b0);
      expect_ins(32'h0034_8493, 32'h4, 1'b1, 1'b0);
      expect_ins(32'h0040_0513, 32'h6, 1'b1, 1'b0);
      fetch_valid = 1'b1;
      fetch_data  = 32'h0409_0405;
      @(posedge clk);
      #1;
      fetch_data = 32'h4511_048D;
      @(posedge clk);
      #1;
      fetch_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         check("full_fetch_ready", 32'(fetch_ready), 32'd0);
         check("stall_instruction", out_instruction, 32'h0014_0413);
         check("stall_pc", out_pc, 32'h0);
         @(posedge clk);
         #1;
      end
      fetch_valid = 1'b0;
      out_ready   = 1'b1;
      wait_drain(20);

      // flush with data queued empties the queue next cycle
      out_ready = 1'b0;
      send_word(32'h0405_0405);
      check("pre_flush_valid", 32'(out_valid), 32'd1);
      do_flush(32'h40);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_fetch_ready", 32'(fetch_ready), 32'd1);
      check("flush_out_pc", out_pc, 32'h40);
      out_ready = 1'b1;
      expect_ins(32'h0014_0413, 32'h40, 1'b1, 1'b0);
      expect_ins(32'h0024_0413, 32'h42, 1'b1, 1'b0);
      send_word(32'h0409_0405);
      wait_drain(20);

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      send_word(32'h0405_0405);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_pc", out_pc, 32'h0);
      check("midrst_fetch_ready", 32'(fetch_ready), 32'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
